// File: rtl/unsigned_mul_8x8_ha_array_reduce.sv
// Final reduction stage of the 8x8 unsigned half-adder-array multiplier:
// folds the four ha_array row vectors into a 16-bit product over a 2-deep elastic pipe.
module unsigned_mul_8x8_ha_array_reduce #(
  parameter int CNT_W  = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       ha_array_0_t,
  input  logic [6:0]       ha_array_0_b,
  input  logic [8:0]       ha_array_1_t,
  input  logic [6:0]       ha_array_1_b,
  input  logic [8:0]       ha_array_2_t,
  input  logic [6:0]       ha_array_2_b,
  input  logic [8:0]       ha_array_3_t,
  input  logic [6:0]       ha_array_3_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic             out_ovf,
  output logic [CNT_W-1:0] done_cnt
);

  logic [8:0] row_t   [4];
  logic [6:0] row_b   [4];
  logic [9:0] row_val [4];

  assign row_t[0] = ha_array_0_t;
  assign row_t[1] = ha_array_1_t;
  assign row_t[2] = ha_array_2_t;
  assign row_t[3] = ha_array_3_t;
  assign row_b[0] = ha_array_0_b;
  assign row_b[1] = ha_array_1_b;
  assign row_b[2] = ha_array_2_b;
  assign row_b[3] = ha_array_3_b;

  // Bottom vector sits two bit positions above its row's top vector.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_val[gi] = 10'(row_t[gi]) + 10'({row_b[gi], 2'b00});
  end

  logic             s1_valid_q, s1_valid_d;
  logic [12:0]      p01_q, p01_d;
  logic [12:0]      p23_q, p23_d;
  logic             s2_valid_q, s2_valid_d;
  logic [15:0]      out_p_q, out_p_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  logic [16:0] sum_s;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_adv;
    in_ready = !s1_valid_q || s2_adv;
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
    sum_s    = 17'(p01_q) + {p23_q, 4'b0000};

    s1_valid_d = s1_valid_q;
    p01_d      = p01_q;
    p23_d      = p23_q;
    s2_valid_d = s2_valid_q;
    out_p_d    = out_p_q;
    out_ovf_d  = out_ovf_q;
    done_cnt_d = done_cnt_q + CNT_W'(out_fire);

    if (in_fire) begin
      s1_valid_d = 1'b1;
      p01_d      = 13'(row_val[0]) + 13'({row_val[1], 2'b00});
      p23_d      = 13'(row_val[2]) + 13'({row_val[3], 2'b00});
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Output registers only change on a refill, so they hold while stalled.
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      out_ovf_d  = sum_s[16];
      out_p_d    = (SAT_EN && sum_s[16]) ? 16'hFFFF : sum_s[15:0];
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p01_q      <= '0;
      p23_q      <= '0;
      s2_valid_q <= 1'b0;
      out_p_q    <= '0;
      out_ovf_q  <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p01_q      <= p01_d;
      p23_q      <= p23_d;
      s2_valid_q <= s2_valid_d;
      out_p_q    <= out_p_d;
      out_ovf_q  <= out_ovf_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_p     = out_p_q;
  assign out_ovf   = out_ovf_q;
  assign done_cnt  = done_cnt_q;

endmodule
